// File: rtl/ofdm_frame_sequencer_pkg.sv
// ofdm_pkg: shared state encoding, payload width and marker byte for the OFDM receive chain.
package ofdm_pkg;
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FFT_KICK = 3'd1,
      S_FFT_WAIT = 3'd2,
      S_DEM_KICK = 3'd3,
      S_DEM_WAIT = 3'd4,
      S_RELEASE  = 3'd5
   } state_e;
   localparam int RES_W = 96;
   localparam logic [7:0] MARKER = 8'h55;
endpackage

// File: rtl/ofdm_frame_sequencer_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/ofdm_frame_sequencer.sv
// ofdm_frame_sequencer: runs FFT then demod for one captured frame, with per-stage
// timeouts, a single-slot valid/ready payload register and saturating statistics.
module ofdm_frame_sequencer #(
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CNT_W          = 16,
   parameter int RES_W          = ofdm_pkg::RES_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             buf_full,
   output logic             buf_release,
   output logic             fft_start,
   input  logic             fft_done,
   output logic             demod_start,
   input  logic             demod_finish,
   input  logic             demod_success,
   input  logic [RES_W-1:0] demod_res,
   output logic [RES_W-1:0] res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] timeout_cnt,
   output logic [CNT_W-1:0] ovf_cnt
);
   import ofdm_pkg::*;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   state_e           state_q;
   logic [TW-1:0]    timer_q;
   logic             fft_start_q, demod_start_q, buf_release_q, res_valid_q;
   logic [RES_W-1:0] res_data_q;
   logic             fft_wait, dem_wait, finish, slot_busy, expired;
   logic             inc_frame, inc_err, inc_to, inc_ovf;
   assign fft_wait  = state_q == S_FFT_WAIT;
   assign dem_wait  = state_q == S_DEM_WAIT;
   assign finish    = dem_wait && demod_finish;
   assign slot_busy = res_valid_q && !res_ready;
   assign expired   = timer_q == T_LAST;
   assign inc_frame = finish && demod_success && !slot_busy;
   assign inc_ovf   = finish && demod_success && slot_busy;
   assign inc_err   = finish && !demod_success;
   // a completion on the final wait cycle takes priority over the timeout
   assign inc_to    = expired && ((fft_wait && !fft_done) || (dem_wait && !demod_finish));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q       <= S_IDLE;
         timer_q       <= '0;
         fft_start_q   <= 1'b0;
         demod_start_q <= 1'b0;
         buf_release_q <= 1'b0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
      end else begin
         fft_start_q   <= 1'b0;
         demod_start_q <= 1'b0;
         buf_release_q <= 1'b0;
         if (inc_frame) res_data_q <= demod_res;
         res_valid_q <= inc_frame || slot_busy;
         case (state_q)
            S_IDLE:
               if (enable && buf_full) begin
                  state_q     <= S_FFT_KICK;
                  fft_start_q <= 1'b1;
               end
            S_FFT_KICK: begin
               timer_q <= '0;
               state_q <= S_FFT_WAIT;
            end
            S_FFT_WAIT:
               if (fft_done) begin
                  state_q       <= S_DEM_KICK;
                  demod_start_q <= 1'b1;
               end else if (expired) begin
                  state_q       <= S_RELEASE;
                  buf_release_q <= 1'b1;
               end else timer_q <= timer_q + 1'b1;
            S_DEM_KICK: begin
               timer_q <= '0;
               state_q <= S_DEM_WAIT;
            end
            S_DEM_WAIT:
               if (demod_finish || expired) begin
                  state_q       <= S_RELEASE;
                  buf_release_q <= 1'b1;
               end else timer_q <= timer_q + 1'b1;
            default: state_q <= S_IDLE;
         endcase
      end
   assign fft_start   = fft_start_q;
   assign demod_start = demod_start_q;
   assign buf_release = buf_release_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign busy        = state_q != S_IDLE;
   sat_counter #(.CNT_W(CNT_W)) u_frame (.clk(clk), .rst(rst), .inc(inc_frame), .q(frame_cnt));
   sat_counter #(.CNT_W(CNT_W)) u_err   (.clk(clk), .rst(rst), .inc(inc_err),   .q(err_cnt));
   sat_counter #(.CNT_W(CNT_W)) u_to    (.clk(clk), .rst(rst), .inc(inc_to),    .q(timeout_cnt));
   sat_counter #(.CNT_W(CNT_W)) u_ovf   (.clk(clk), .rst(rst), .inc(inc_ovf),   .q(ovf_cnt));
endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// tb_ofdm_frame_sequencer: directed scenarios on a default instance and a short-timeout,
// 2-bit-counter instance that share the same stimulus.
module tb_ofdm_frame_sequencer;
   localparam int RW = 96;
   localparam logic [RW-1:0] R1 = 96'h5555_1234_5678_9ABC_DEF0_AA55;
   localparam logic [RW-1:0] R2 = 96'h55AA_0F0F_F0F0_C3C3_3C3C_AA55;
   logic clk = 0, rst = 0, enable = 0, buf_full = 0, fft_done = 0;
   logic demod_finish = 0, demod_success = 0, res_ready = 0;
   logic [RW-1:0] demod_res = '0;
   logic buf_release, fft_start, demod_start, res_valid, busy;
   logic [RW-1:0] res_data;
   logic [15:0] frame_cnt, err_cnt, timeout_cnt, ovf_cnt;
   logic s_buf_release, s_fft_start, s_demod_start, s_res_valid, s_busy;
   logic [RW-1:0] s_res_data;
   logic [1:0] s_frame_cnt, s_err_cnt, s_timeout_cnt, s_ovf_cnt;
   int vectors = 0, miscompares = 0;
   int n_fft = 0, n_dem = 0, n_rel = 0, n_vld = 0, s_n_dem = 0;

   always #5 clk = ~clk;

   ofdm_frame_sequencer dut (
      .clk(clk), .rst(rst), .enable(enable), .buf_full(buf_full),
      .buf_release(buf_release), .fft_start(fft_start), .fft_done(fft_done),
      .demod_start(demod_start), .demod_finish(demod_finish),
      .demod_success(demod_success), .demod_res(demod_res),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt), .timeout_cnt(timeout_cnt), .ovf_cnt(ovf_cnt)
   );

   ofdm_frame_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .enable(enable), .buf_full(buf_full),
      .buf_release(s_buf_release), .fft_start(s_fft_start), .fft_done(fft_done),
      .demod_start(s_demod_start), .demod_finish(demod_finish),
      .demod_success(demod_success), .demod_res(demod_res),
      .res_data(s_res_data), .res_valid(s_res_valid), .res_ready(res_ready), .busy(s_busy),
      .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt), .timeout_cnt(s_timeout_cnt), .ovf_cnt(s_ovf_cnt)
   );

   always @(posedge clk) begin
      #2;
      n_fft   += int'(fft_start);
      n_dem   += int'(demod_start);
      n_rel   += int'(buf_release);
      n_vld   += int'(res_valid);
      s_n_dem += int'(s_demod_start);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_for(input int which, input string tag);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         hit = (which == 0) ? fft_start : (which == 1) ? demod_start : s_fft_start;
         if (!hit) step(1);
      end
      vectors++;
      if (!hit) begin miscompares++; $display("FAIL %s: pulse not seen within 40 cycles, got 0 need 1", tag); end
   endtask

   task automatic apply_reset();
      enable = 0; buf_full = 0; fft_done = 0; demod_finish = 0; demod_success = 0; res_ready = 0;
      @(negedge clk);
      rst = 1;
      step(2);
      rst = 0;
      step(1);
      n_fft = 0; n_dem = 0; n_rel = 0; n_vld = 0; s_n_dem = 0;
   endtask

   // returns on the negedge where the RELEASE state is visible
   task automatic run_frame(input int d_fft, input int d_dem, input logic succ, input logic [RW-1:0] res);
      enable = 1; buf_full = 1;
      wait_for(0, "fft_start");
      buf_full = 0;
      step(d_fft);
      fft_done = 1;
      step(1);
      fft_done = 0;
      wait_for(1, "demod_start");
      step(d_dem);
      demod_finish = 1; demod_success = succ; demod_res = res;
      step(1);
      demod_finish = 0; demod_success = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      vectors += 6;
      if ({busy, fft_start, demod_start, buf_release, res_valid} !== 5'b0) begin miscompares++; $display("FAIL reset_ctl: got %b need 00000", {busy, fft_start, demod_start, buf_release, res_valid}); end
      if (res_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h need 0", res_data); end
      if ({frame_cnt, err_cnt, timeout_cnt, ovf_cnt} !== 64'd0) begin miscompares++; $display("FAIL reset_cnt: got %h need 0", {frame_cnt, err_cnt, timeout_cnt, ovf_cnt}); end
      if ({s_busy, s_res_valid, s_frame_cnt, s_err_cnt, s_timeout_cnt, s_ovf_cnt} !== 10'd0) begin miscompares++; $display("FAIL reset_s: got %h need 0", {s_busy, s_res_valid, s_frame_cnt, s_err_cnt, s_timeout_cnt, s_ovf_cnt}); end
      buf_full = 1;
      step(3);
      if (busy !== 1'b0) begin miscompares++; $display("FAIL disabled_idle: busy got %b need 0", busy); end
      if (n_fft !== 0) begin miscompares++; $display("FAIL disabled_kick: fft_start pulses got %0d need 0", n_fft); end
      buf_full = 0;
   endtask

   task automatic test_normal();
      apply_reset();
      res_ready = 1;
      run_frame(10, 20, 1'b1, R1);
      vectors += 10;
      if (buf_release !== 1'b1) begin miscompares++; $display("FAIL normal_release: got %b need 1", buf_release); end
      if (res_valid !== 1'b1) begin miscompares++; $display("FAIL normal_valid: got %b need 1", res_valid); end
      if (res_data !== R1) begin miscompares++; $display("FAIL normal_data: got %h need %h", res_data, R1); end
      if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL normal_frame_cnt: got %0d need 1", frame_cnt); end
      step(1);
      if (res_valid !== 1'b0) begin miscompares++; $display("FAIL normal_valid_clear: got %b need 0", res_valid); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL normal_idle: busy got %b need 0", busy); end
      step(3);
      if (n_fft !== 1) begin miscompares++; $display("FAIL normal_fft_pulses: got %0d need 1", n_fft); end
      if (n_dem !== 1) begin miscompares++; $display("FAIL normal_dem_pulses: got %0d need 1", n_dem); end
      if (n_rel !== 1) begin miscompares++; $display("FAIL normal_rel_pulses: got %0d need 1", n_rel); end
      if (n_vld !== 1) begin miscompares++; $display("FAIL normal_valid_cycles: got %0d need 1", n_vld); end
   endtask

   task automatic test_bad();
      apply_reset();
      res_ready = 1;
      run_frame(3, 5, 1'b0, R2);
      vectors += 7;
      if (buf_release !== 1'b1) begin miscompares++; $display("FAIL bad_release: got %b need 1", buf_release); end
      if (err_cnt !== 16'd1) begin miscompares++; $display("FAIL bad_err_cnt: got %0d need 1", err_cnt); end
      if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL bad_frame_cnt: got %0d need 0", frame_cnt); end
      if (res_valid !== 1'b0) begin miscompares++; $display("FAIL bad_valid: got %b need 0", res_valid); end
      if (res_data !== '0) begin miscompares++; $display("FAIL bad_data: got %h need 0", res_data); end
      step(3);
      if (n_rel !== 1) begin miscompares++; $display("FAIL bad_rel_pulses: got %0d need 1", n_rel); end
      if (n_vld !== 0) begin miscompares++; $display("FAIL bad_valid_cycles: got %0d need 0", n_vld); end
   endtask

   task automatic test_timeout();
      apply_reset();
      enable = 1; buf_full = 1;
      wait_for(2, "s_fft_start");
      buf_full = 0;
      step(16);
      vectors += 7;
      if (s_timeout_cnt !== 2'd0) begin miscompares++; $display("FAIL to_early_cnt: got %0d need 0", s_timeout_cnt); end
      if (s_buf_release !== 1'b0) begin miscompares++; $display("FAIL to_early_release: got %b need 0", s_buf_release); end
      step(1);
      if (s_timeout_cnt !== 2'd1) begin miscompares++; $display("FAIL to_cnt: got %0d need 1", s_timeout_cnt); end
      if (s_buf_release !== 1'b1) begin miscompares++; $display("FAIL to_release: got %b need 1", s_buf_release); end
      step(1);
      if (s_busy !== 1'b0) begin miscompares++; $display("FAIL to_idle: busy got %b need 0", s_busy); end
      if (s_n_dem !== 0) begin miscompares++; $display("FAIL to_no_demod: demod_start pulses got %0d need 0", s_n_dem); end
      if (s_err_cnt !== 2'd0) begin miscompares++; $display("FAIL to_err_cnt: got %0d need 0", s_err_cnt); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      run_frame(1, 1, 1'b1, R1);
      run_frame(1, 1, 1'b1, R2);
      vectors += 7;
      if (res_data !== R1) begin miscompares++; $display("FAIL ovf_data_held: got %h need %h", res_data, R1); end
      if (ovf_cnt !== 16'd1) begin miscompares++; $display("FAIL ovf_cnt: got %0d need 1", ovf_cnt); end
      if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL ovf_frame_cnt: got %0d need 1", frame_cnt); end
      if (res_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid: got %b need 1", res_valid); end
      if (n_fft !== 2) begin miscompares++; $display("FAIL ovf_fft_pulses: got %0d need 2", n_fft); end
      res_ready = 1;
      step(1);
      if (res_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_valid_clear: got %b need 0", res_valid); end
      if (res_data !== R1) begin miscompares++; $display("FAIL ovf_data_after: got %h need %h", res_data, R1); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      run_frame(1, 1, 1'b1, R1);
      step(1);
      enable = 1; buf_full = 1;
      wait_for(0, "mid_fft_start");
      buf_full = 0;
      step(1);
      fft_done = 1;
      step(1);
      fft_done = 0;
      wait_for(1, "mid_demod_start");
      step(3);
      n_rel = 0;
      #2 rst = 1;
      #1;
      vectors += 8;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b need 0", busy); end
      if (res_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b need 0", res_valid); end
      if (frame_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_frame_cnt: got %0d need 0", frame_cnt); end
      if (res_data !== '0) begin miscompares++; $display("FAIL mid_data: got %h need 0", res_data); end
      step(2);
      rst = 0;
      step(2);
      if (n_rel !== 0) begin miscompares++; $display("FAIL mid_no_release: got %0d need 0", n_rel); end
      res_ready = 1;
      run_frame(2, 2, 1'b1, R2);
      if (frame_cnt !== 16'd1) begin miscompares++; $display("FAIL mid_after_cnt: got %0d need 1", frame_cnt); end
      if (res_data !== R2) begin miscompares++; $display("FAIL mid_after_data: got %h need %h", res_data, R2); end
      if (buf_release !== 1'b1) begin miscompares++; $display("FAIL mid_after_release: got %b need 1", buf_release); end
   endtask

   task automatic test_saturation();
      apply_reset();
      res_ready = 1;
      for (int i = 0; i < 5; i++) run_frame(1, 2, 1'b0, R2);
      vectors += 8;
      if (s_err_cnt !== 2'd3) begin miscompares++; $display("FAIL sat_err_cnt: got %0d need 3", s_err_cnt); end
      if (err_cnt !== 16'd5) begin miscompares++; $display("FAIL wide_err_cnt: got %0d need 5", err_cnt); end
      run_frame(1, 16, 1'b1, R1);
      if (s_timeout_cnt !== 2'd0) begin miscompares++; $display("FAIL tie_timeout_cnt: got %0d need 0", s_timeout_cnt); end
      if (s_frame_cnt !== 2'd1) begin miscompares++; $display("FAIL tie_frame_cnt: got %0d need 1", s_frame_cnt); end
      if (s_res_data !== R1) begin miscompares++; $display("FAIL tie_data: got %h need %h", s_res_data, R1); end
      if (s_buf_release !== 1'b1) begin miscompares++; $display("FAIL tie_release: got %b need 1", s_buf_release); end
      run_frame(1, 17, 1'b1, R2);
      if (s_timeout_cnt !== 2'd1) begin miscompares++; $display("FAIL late_timeout_cnt: got %0d need 1", s_timeout_cnt); end
      if (s_frame_cnt !== 2'd1) begin miscompares++; $display("FAIL late_frame_cnt: got %0d need 1", s_frame_cnt); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_bad();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
